mul_datapath: RTL and testbench

Shift-add multiplier datapath driven directly by the multiplier control FSM (`load`, `ad`, `Sh`, `done`). It feeds back the multiplier LSB `m` and the last-shift flag `k`. It holds the operands, the accumulator and the iteration counter, and presents a registered 2·WIDTH-bit product when the controller signals completion.

---
 rtl/mul_datapath.sv | 98 +++++++++
 tb/tb_mul_datapath.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_datapath.sv
// mul_datapath: shift-add multiplier datapath driven by an external control FSM.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   load            - capture mcand/mplier, clear accumulator and counter
//   ad              - add multiplicand into the accumulator upper half
//   Sh              - shift accumulator right by one, advance counter
//   done            - latch accumulator into the product register
//   mcand, mplier   - WIDTH-bit operands, sampled on load
//   m               - current multiplier bit (ACC[0])
//   k               - last shift flag (cnt == WIDTH-1)
//   product         - registered 2*WIDTH-bit unsigned product
//   product_valid   - product holds the latest completed result
module mul_datapath #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 ad,
  input  logic                 Sh,
  input  logic                 done,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 m,
  output logic                 k,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_valid
);

  logic [WIDTH-1:0]   mc_q,   mc_d;
  logic [2*WIDTH:0]   acc_q,  acc_d;
  logic [CW-1:0]      cnt_q,  cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               pv_q,   pv_d;

  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt_inc;

  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mc_q};

  // Explicit wrap on the last shift keeps the counter correct when WIDTH
  // is not a power of two.
  assign cnt_inc = k ? '0 : cnt_q + CW'(1);

  assign m = acc_q[0];
  assign k = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    mc_d   = mc_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    pv_d   = pv_q;

    if (load) begin
      mc_d  = mcand;
      acc_d = {{(WIDTH + 1){1'b0}}, mplier};
      cnt_d = '0;
      pv_d  = 1'b0;
    end else if (ad && Sh) begin
      acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
      cnt_d = cnt_inc;
    end else if (ad) begin
      acc_d = {sum, acc_q[WIDTH-1:0]};
    end else if (Sh) begin
      acc_d = acc_q >> 1;
      cnt_d = cnt_inc;
    end

    // done uses the pre-update accumulator and overrides load's clear of valid.
    if (done) begin
      prod_d = acc_q[2*WIDTH-1:0];
      pv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
      pv_q   <= 1'b0;
    end else begin
      mc_q   <= mc_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
      pv_q   <= pv_d;
    end
  end

  assign product       = prod_q;
  assign product_valid = pv_q;

endmodule

// File: tb/tb_mul_datapath.sv
module tb_mul_datapath;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst, load, ad, Sh, done;
  logic [W-1:0]   mcand, mplier;
  logic           m, k;
  logic [2*W-1:0] product;
  logic           product_valid;

  int checks = 0;
  int errors = 0;

  mul_datapath #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .ad            (ad),
    .Sh            (Sh),
    .done          (done),
    .mcand         (mcand),
    .mplier        (mplier),
    .m             (m),
    .k             (k),
    .product       (product),
    .product_valid (product_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    load = 1'b0; ad = 1'b0; Sh = 1'b0; done = 1'b0;
  endtask

  // Start a multiply: load is applied on the next rising edge.
  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    idle();
    load = 1'b1; mcand = a; mplier = b;
  endtask

  // Shift phase: ad follows the model's multiplier bit; m and k are checked
  // against what the operand and shift index say they must be.
  task automatic do_shifts(input logic [W-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle();
      if (i == 0) chk("valid_cleared_by_load", {63'd0, product_valid}, 64'd0);
      chk("m_bit", {63'd0, m}, {63'd0, b[i]});
      chk("k_flag", {63'd0, k}, {63'd0, (i == W - 1)});
      Sh = 1'b1;
      ad = b[i];
    end
  endtask

  task automatic do_done_and_check(input logic [2*W-1:0] exp, input string name);
    @(negedge clk);
    idle();
    done = 1'b1;
    @(negedge clk);
    idle();
    chk(name, {56'd0, product}, {56'd0, exp});
    chk("valid_after_done", {63'd0, product_valid}, 64'd1);
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input string name);
    do_load(a, b);
    do_shifts(b, W);
    do_done_and_check(exp, name);
  endtask

  initial begin
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] held;

    tbl[0] = '{a: 4'd13, b: 4'd11, p: 8'd143};
    tbl[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
    tbl[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
    tbl[3] = '{a: 4'd9,  b: 4'd0,  p: 8'd0};
    tbl[4] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};

    // Reset with random commands active.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      {load, ad, Sh, done} = 4'($urandom);
      mcand  = W'($urandom);
      mplier = W'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("rst_product", {56'd0, product}, 64'd0);
    chk("rst_valid", {63'd0, product_valid}, 64'd0);
    chk("rst_m", {63'd0, m}, 64'd0);
    chk("rst_k", {63'd0, k}, 64'd0);

    // Directed table.
    for (int i = 0; i < 5; i++)
      run_mul(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("table_%0d", i));

    // Restart mid-operation.
    do_load(4'd7, 4'd5);
    do_shifts(4'd5, 2);
    run_mul(4'd3, 4'd6, 8'd18, "restart_3x6");

    // Reset mid-operation.
    do_load(4'd5, 4'd7);
    do_shifts(4'd7, 2);
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_product", {56'd0, product}, 64'd0);
    chk("midrst_valid", {63'd0, product_valid}, 64'd0);
    chk("midrst_m", {63'd0, m}, 64'd0);
    chk("midrst_k", {63'd0, k}, 64'd0);
    run_mul(4'd2, 4'd3, 8'd6, "after_rst_2x3");

    // Hold: product and valid stay put without done.
    held = 8'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Sh = 1'($urandom);
      ad = 1'($urandom);
      if (i > 0) begin
        chk("hold_product", {56'd0, product}, {56'd0, held});
        chk("hold_valid", {63'd0, product_valid}, 64'd1);
      end
    end

    // done and load together: product takes the pre-load ACC, valid ends at 1.
    run_mul(4'd12, 4'd10, 8'd120, "pre_collide_12x10");
    @(negedge clk);
    idle();
    done = 1'b1; load = 1'b1; mcand = 4'd5; mplier = 4'd6;
    @(negedge clk);
    idle();
    chk("collide_product", {56'd0, product}, 64'd120);
    chk("collide_valid", {63'd0, product_valid}, 64'd1);
    chk("collide_m", {63'd0, m}, 64'd0);
    chk("collide_k", {63'd0, k}, 64'd0);
    // The load still took effect: finish the 5x6 multiply from here.
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      idle();
      chk("collide_m_seq", {63'd0, m}, {63'd0, (i < 1 ? 1'b0 : ((4'd6 >> i) & 4'd1) != 0)});
      Sh = 1'b1;
      ad = m;
    end
    do_done_and_check(8'd30, "collide_then_5x6");

    // Randomized operands against a plain arithmetic model.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_mul(ra, rb, (2*W)'(ra) * (2*W)'(rb), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
